// File: rtl/tstate_pkg.sv
// Shared constants and helpers for the T-state sequencer.
// Optional instruction counter: TSTATE_INSTR_COUNT_EN.
package tstate_pkg;

  localparam int NUM_T_DEF     = 18;
  localparam int FETCH_LEN_DEF = 3;

  localparam int T01_IDX = 0;
  localparam int T02_IDX = 1;
  localparam int T03_IDX = 2;
  localparam int T04_IDX = 3;
  localparam int T05_IDX = 4;
  localparam int T06_IDX = 5;
  localparam int T07_IDX = 6;
  localparam int T08_IDX = 7;
  localparam int T09_IDX = 8;
  localparam int T10_IDX = 9;
  localparam int T11_IDX = 10;
  localparam int T12_IDX = 11;
  localparam int T13_IDX = 12;
  localparam int T14_IDX = 13;
  localparam int T15_IDX = 14;
  localparam int T16_IDX = 15;
  localparam int T17_IDX = 16;
  localparam int T18_IDX = 17;

  // Widest legal ring is 64 states; callers truncate.
  function automatic logic [63:0] onehot_of(input int idx);
    logic [63:0] v;
    v = 64'd1 << idx;
    return v;
  endfunction

endpackage

// File: rtl/tstate_onehot_chk.sv
// One-hot to index encoder with an exactly-one-bit-set flag.
// Part of the tstate_sequencer (TSTATE_INSTR_COUNT_EN optional).
module tstate_onehot_chk #(
  parameter int N = 18,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         legal_o
);

  logic [6:0] ones;

  always_comb begin
    ones = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        ones = ones + 7'd1;
        idx_o = idx_o | W'(i);
      end
    end
    legal_o = (ones == 7'd1);
  end

endmodule

// File: rtl/tstate_sequencer.sv
// One-hot T-state ring with programmable length, hold and recovery.
// Define TSTATE_INSTR_COUNT_EN to add the 16-bit instr_count output.
module tstate_sequencer
  import tstate_pkg::*;
#(
  parameter int NUM_T     = NUM_T_DEF,
  parameter int FETCH_LEN = FETCH_LEN_DEF,
  parameter int IDX_W     = $clog2(NUM_T)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             run,
  input  logic             early_end,
  input  logic [IDX_W-1:0] t_limit,
  output logic [NUM_T-1:0] state,
  output logic [IDX_W-1:0] t_idx,
  output logic             fetch,
  output logic             last_t,
  output logic             instr_done,
  output logic             err
`ifdef TSTATE_INSTR_COUNT_EN
  ,
  output logic [15:0]      instr_count
`endif
);

  localparam logic [NUM_T-1:0] T1_VEC =
    NUM_T'(onehot_of(T01_IDX));
  localparam logic [IDX_W-1:0] LIM_MAX =
    IDX_W'(NUM_T - 1);
  localparam int FW = IDX_W + 1;
  localparam logic [FW-1:0] FETCH_V = FW'(FETCH_LEN);

  logic [NUM_T-1:0] state_q, state_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] eff_lim;
  logic [IDX_W-1:0] idx;
  logic             legal;
  logic             wrap;

  tstate_onehot_chk #(
    .N (NUM_T),
    .W (IDX_W)
  ) u_chk (
    .vec_i   (state_q),
    .idx_o   (idx),
    .legal_o (legal)
  );

  assign eff_lim = (t_limit > LIM_MAX) ? LIM_MAX : t_limit;

  // Top of ring always ends the instruction, so an index
  // already past a lowered limit still wraps to T1.
  assign wrap = early_end
              | (idx == eff_lim)
              | (idx == LIM_MAX);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (!legal) begin
      state_d = T1_VEC;
      err_d   = 1'b1;
    end else if (run && wrap) begin
      state_d = T1_VEC;
      done_d  = 1'b1;
      cnt_d   = cnt_q + 16'd1;
    end else if (run) begin
      state_d = state_q << 1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= T1_VEC;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state      = state_q;
  assign t_idx      = idx;
  assign fetch      = ({1'b0, idx} < FETCH_V);
  assign last_t     = run & wrap;
  assign instr_done = done_q;
  assign err        = err_q;

`ifdef TSTATE_INSTR_COUNT_EN
  assign instr_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
`endif

endmodule
